// File: rtl/sel_debouncer.sv
// rtl/sel_debouncer.sv - two-flop synchronizer plus qualification FSM producing a clean mux select
module sel_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit INIT_SEL      = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BtnIn,
  output logic SEL,
  output logic SelRise,
  output logic SelFall,
  output logic Busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Counter value seen on the last of the STABLE_CYCLES qualifying samples.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam state_t           STATE_RST = INIT_SEL ? IDLE_HIGH : IDLE_LOW;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Synchronizer next values: BtnIn only ever reaches s1, and only s2 feeds the FSM.
  always_comb begin
    s1_d = BtnIn;
    s2_d = s1_q;
  end

  // Synchronizer flops, preloaded with the reset select level so reset does not look like an edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q <= INIT_SEL;
      s2_q <= INIT_SEL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Qualification FSM: a new level must be seen STABLE_CYCLES times in a row before SEL follows it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
          sel_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
          sel_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = STATE_RST;
        cnt_d   = CNT_ZERO;
        sel_d   = INIT_SEL;
      end
    endcase

    // Busy is registered from the next state so it lines up with the WAIT_* residency.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  // FSM and output registers; every output comes straight from a flop.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= STATE_RST;
      cnt_q   <= CNT_ZERO;
      sel_q   <= INIT_SEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign SEL     = sel_q;
  assign SelRise = rise_q;
  assign SelFall = fall_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_sel_debouncer.sv
// tb/tb_sel_debouncer.sv - randomized and directed self-checking bench for sel_debouncer
module tb_sel_debouncer;

  localparam int S    = 4;
  localparam int CW   = 5;
  localparam bit INIT = 1'b0;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic BtnIn = 1'b0;
  logic SEL, SelRise, SelFall, Busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: synchronizer pipeline plus a run length of samples disagreeing with SEL.
  bit m_p1, m_p2, m_sel, m_rise, m_fall, m_busy;
  int m_run;

  sel_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_W        (CW),
    .INIT_SEL     (INIT)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .BtnIn  (BtnIn),
    .SEL    (SEL),
    .SelRise(SelRise),
    .SelFall(SelFall),
    .Busy   (Busy)
  );

  always #5 Clock = ~Clock;

  // Drive one cycle, advance the model over the same edge, then settle 1 time unit past the edge.
  task automatic step(input bit rst, input bit btn);
    bit smp;
    Reset = rst;
    BtnIn = btn;
    @(posedge Clock);
    if (rst) begin
      m_p1 = INIT; m_p2 = INIT; m_sel = INIT;
      m_run = 0; m_rise = 0; m_fall = 0; m_busy = 0;
    end else begin
      smp = m_p2;
      m_rise = 0;
      m_fall = 0;
      if (smp != m_sel) m_run++;
      else m_run = 0;
      if (m_run == S) begin
        m_sel  = smp;
        m_rise = smp;
        m_fall = !smp;
        m_run  = 0;
      end
      m_busy = (m_run != 0);
      m_p2 = m_p1;
      m_p1 = btn;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {INIT, 3'b000}) begin
        n_fail++;
        $display("FAIL reset_hold cycle=%0d got=%b want=%b", i, {SEL, SelRise, SelFall, Busy}, {INIT, 3'b000});
      end
    end
    n_tests++;
    if (dut.cnt_q !== CW'(0)) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL reset_release_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if (SEL !== (k >= 6)) begin
        n_fail++;
        $display("FAIL reset_release_latency k=%0d got=%b want=%b", k, SEL, (k >= 6));
      end
    end
  endtask

  task automatic test_fall();
    int busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0);
      if (Busy === 1'b1) busy_cnt++;
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL fall_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if ({SEL, SelFall, SelRise} !== {(k < 6), (k == 6), 1'b0}) begin
        n_fail++;
        $display("FAIL fall_timing k=%0d got=%b want=%b", k, {SEL, SelFall, SelRise}, {(k < 6), (k == 6), 1'b0});
      end
    end
    n_tests++;
    if (busy_cnt != S - 1) begin
      n_fail++;
      $display("FAIL fall_busy_len got=%0d want=%0d", busy_cnt, S - 1);
    end
  endtask

  task automatic test_rise();
    int busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      if (Busy === 1'b1) busy_cnt++;
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL rise_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if ({SEL, SelRise, SelFall} !== {(k >= 6), (k == 6), 1'b0}) begin
        n_fail++;
        $display("FAIL rise_timing k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall}, {(k >= 6), (k == 6), 1'b0});
      end
    end
    n_tests++;
    if (busy_cnt != S - 1) begin
      n_fail++;
      $display("FAIL rise_busy_len got=%0d want=%0d", busy_cnt, S - 1);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0);
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL rise_return_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
    end
  endtask

  task automatic test_toggle();
    int busy_seen = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, (i < 20) ? ((i % 2) == 0) : 1'b0);
      if (Busy === 1'b1) busy_seen++;
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL toggle_model i=%0d got=%b want=%b", i, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if ({SEL, SelRise, SelFall} !== 3'b000) begin
        n_fail++;
        $display("FAIL toggle_quiet i=%0d got=%b want=000", i, {SEL, SelRise, SelFall});
      end
    end
    n_tests++;
    if (busy_seen == 0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_busy seen=%0d final=%b want seen>0 final=0", busy_seen, Busy);
    end
  endtask

  task automatic test_pulse();
    int rises = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, k <= S - 1);
      if (SelRise === 1'b1) rises++;
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL pulse_short_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
    end
    n_tests++;
    if (rises != 0 || SEL !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_short_reject rises=%0d sel=%b want rises=0 sel=0", rises, SEL);
    end
    rises = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, k <= S);
      if (SelRise === 1'b1) rises++;
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL pulse_exact_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      if (k == 6) begin
        n_tests++;
        if ({SEL, SelRise} !== 2'b11) begin
          n_fail++;
          $display("FAIL pulse_exact_accept got=%b want=11", {SEL, SelRise});
        end
      end
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL pulse_exact_rises got=%0d want=1", rises);
    end
  endtask

  task automatic test_reset_midqual();
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1);
    n_tests++;
    if (dut.cnt_q !== CW'(m_run) || m_run != 2 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midqual_setup cnt=%0d busy=%b want cnt=2 busy=1", dut.cnt_q, Busy);
    end
    step(1'b1, 1'b1);
    n_tests++;
    if ({SEL, SelRise, SelFall, Busy, dut.cnt_q} !== {INIT, 3'b000, CW'(0)}) begin
      n_fail++;
      $display("FAIL midqual_reset got=%b want=%b", {SEL, SelRise, SelFall, Busy, dut.cnt_q}, {INIT, 3'b000, CW'(0)});
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL midqual_release_model k=%0d got=%b want=%b", k, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if (SEL !== (k >= 6)) begin
        n_fail++;
        $display("FAIL midqual_requalify k=%0d got=%b want=%b", k, SEL, (k >= 6));
      end
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    int run_left = 0;
    bit rst;
    for (int i = 0; i < 600; i++) begin
      if (run_left == 0) begin
        lvl = ~lvl;
        run_left = $urandom_range(1, 2 * S + 2);
      end
      run_left--;
      rst = ($urandom_range(0, 99) == 0);
      step(rst, lvl);
      n_tests++;
      if ({SEL, SelRise, SelFall, Busy} !== {m_sel, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL random_model i=%0d got=%b want=%b", i, {SEL, SelRise, SelFall, Busy}, {m_sel, m_rise, m_fall, m_busy});
      end
      n_tests++;
      if (SelRise === 1'b1 && SelFall === 1'b1) begin
        n_fail++;
        $display("FAIL random_both_strobes i=%0d got=11 want=not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_toggle();
    test_pulse();
    test_rise();
    test_reset_midqual();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
